// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the traffic light interval timer and
//               the controller FSM that drives it: selector encodings,
//               field widths, reset durations, the timer state type and a
//               helper that resolves an interval selector to a load value.
// Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    // Field widths: programmed durations and the countdown value
    localparam int TIME_W = 4;
    localparam int REM_W  = 5;

    // Interval / parameter selector encodings
    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_DBL  = 2'b11;

    // Reset durations in seconds (all nonzero)
    localparam logic [TIME_W-1:0] DEF_BASE = 4'd6;
    localparam logic [TIME_W-1:0] DEF_EXT  = 4'd3;
    localparam logic [TIME_W-1:0] DEF_YEL  = 4'd2;

    // Countdown FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_e;

    // Seconds to load for a given selector; the double-base choice is the
    // base value shifted left one place, which is why REM_W is one bit wider.
    function automatic logic [REM_W-1:0] interval_load(
        input logic [1:0]        sel,
        input logic [TIME_W-1:0] base,
        input logic [TIME_W-1:0] ext,
        input logic [TIME_W-1:0] yel
    );
        logic [REM_W-1:0] val;
        val = '0;
        case (sel)
            SEL_BASE: val = {1'b0, base};
            SEL_EXT:  val = {1'b0, ext};
            SEL_YEL:  val = {1'b0, yel};
            default:  val = {base, 1'b0};
        endcase
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_interval_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_interval_timer_if
// Description : Controller <-> interval timer bundle.
//   reprogram           : level, write time_value into selected register
//   time_param_selector : register to write (00 base, 01 ext, 10 yel)
//   time_value          : new duration in seconds
//   start               : one-cycle request to load and run an interval
//   interval_sel        : interval to run (11 = double base)
//   busy                : interval running
//   expired             : one-cycle completion pulse
//   remaining           : seconds left in current interval
//   tick_1s             : free-running one-second pulse
//   master modport = controller side, slave modport = timer side.
// Revision    : 1.0  initial release
// ============================================================================
interface traffic_interval_timer_if;
    import traffic_pkg::*;

    logic                reprogram;
    logic [1:0]          time_param_selector;
    logic [TIME_W-1:0]   time_value;
    logic                start;
    logic [1:0]          interval_sel;
    logic                busy;
    logic                expired;
    logic [REM_W-1:0]    remaining;
    logic                tick_1s;

    modport master (
        output reprogram, time_param_selector, time_value, start, interval_sel,
        input  busy, expired, remaining, tick_1s
    );

    modport slave (
        input  reprogram, time_param_selector, time_value, start, interval_sel,
        output busy, expired, remaining, tick_1s
    );

endinterface
`default_nettype wire

// File: rtl/traffic_interval_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides the system clock down to a one-second tick. The
//               counter runs 0..TICK_DIV-1 and wraps; tick_o is asserted
//               combinationally during the last count. clear_i restarts the
//               count at 0 so an interval begins on a whole-second boundary.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clear_i  : restart count at 0 on this edge
//   tick_o   : one-cycle pulse every TICK_DIV cycles
// Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    output logic      tick_o
);

    localparam int                CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || (count_q == C_LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/traffic_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_interval_timer
// Description : Programmable interval timer feeding the traffic light
//               controller. Holds the base / extended / yellow durations,
//               derives the one-second tick and counts a requested interval,
//               returning a one-cycle expiry pulse.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   tmr_if : controller bundle (slave side); see traffic_interval_timer_if
// Revision    : 1.0  initial release
// ============================================================================
module traffic_interval_timer #(
    parameter int          TICK_DIV = 4,
    parameter logic [3:0]  DEF_BASE = traffic_pkg::DEF_BASE,
    parameter logic [3:0]  DEF_EXT  = traffic_pkg::DEF_EXT,
    parameter logic [3:0]  DEF_YEL  = traffic_pkg::DEF_YEL
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    traffic_interval_timer_if.slave   tmr_if
);
    import traffic_pkg::*;

    logic [TIME_W-1:0] base_q;
    logic [TIME_W-1:0] ext_q;
    logic [TIME_W-1:0] yel_q;

    tmr_state_e        state_q;
    tmr_state_e        state_d;
    logic [REM_W-1:0]  rem_q;
    logic [REM_W-1:0]  rem_d;
    logic              exp_q;
    logic              exp_d;
    logic              tick;

    // Starting an interval clears the prescaler so the first decrement
    // lands exactly TICK_DIV cycles after the start edge.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tmr_if.start),
        .tick_o  (tick)
    );

    // Duration registers. A zero value or the reserved selector is dropped.
    // The load path below reads the current register contents, so a start
    // on the same edge as a write still picks up the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= DEF_BASE;
            ext_q  <= DEF_EXT;
            yel_q  <= DEF_YEL;
        end else if (tmr_if.reprogram && (tmr_if.time_value != '0)) begin
            case (tmr_if.time_param_selector)
                SEL_BASE: base_q <= tmr_if.time_value;
                SEL_EXT:  ext_q  <= tmr_if.time_value;
                SEL_YEL:  yel_q  <= tmr_if.time_value;
                default:  ;
            endcase
        end
    end

    // Countdown FSM: next state / outputs
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;

        if (tmr_if.start) begin
            // Reload (also a retrigger). The running interval still reports
            // completion if this edge was its final decrement.
            state_d = RUN;
            rem_d   = interval_load(tmr_if.interval_sel, base_q, ext_q, yel_q);
            if ((state_q == RUN) && tick && (rem_q == REM_W'(1))) begin
                exp_d = 1'b1;
            end
        end else if ((state_q == RUN) && tick) begin
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
                state_d = IDLE;
                exp_d   = 1'b1;
            end
        end
    end

    // Countdown FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
        end
    end

    assign tmr_if.busy      = (state_q == RUN);
    assign tmr_if.expired   = exp_q;
    assign tmr_if.remaining = rem_q;
    assign tmr_if.tick_1s   = tick;

endmodule
`default_nettype wire

// File: tb/tb_traffic_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_interval_timer
// Description : Directed self-checking bench for traffic_interval_timer with
//               TICK_DIV=4 and default durations (base 6, ext 3, yel 2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_interval_timer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_interval_timer_if tif ();

    traffic_interval_timer #(
        .TICK_DIV (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tmr_if (tif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a one-cycle start, then scramble interval_sel to show it is
    // only sampled together with start.
    task automatic start_run(input logic [1:0] sel);
        tif.start        = 1'b1;
        tif.interval_sel = sel;
        step(1);
        tif.start        = 1'b0;
        tif.interval_sel = ~sel;
    endtask

    task automatic reprog(input logic [1:0] sel, input logic [3:0] val);
        tif.reprogram           = 1'b1;
        tif.time_param_selector = sel;
        tif.time_value          = val;
        step(1);
        tif.reprogram           = 1'b0;
    endtask

    // Count edges until expired is seen (bounded); check the count, the
    // state at the pulse, and that the pulse lasts a single cycle.
    task automatic wait_exp(input string tag, input int exp_cycles);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && (k < 200)) begin
            step(1);
            k++;
            if (tif.expired === 1'b1) seen = 1'b1;
        end
        chk({tag, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_cycles));
        chk({tag, "_busy_at_pulse"}, 32'(tif.busy), 32'd0);
        chk({tag, "_rem_at_pulse"}, 32'(tif.remaining), 32'd0);
        step(1);
        chk({tag, "_pulse_width"}, 32'(tif.expired), 32'd0);
    endtask

    // Run n cycles and count expiry pulses seen
    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            step(1);
            if (tif.expired === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;

        tif.reprogram           = 1'b0;
        tif.time_param_selector = 2'b00;
        tif.time_value          = 4'd0;
        tif.start               = 1'b0;
        tif.interval_sel        = 2'b00;

        // Reset state
        #12;
        chk("rst_busy", 32'(tif.busy), 32'd0);
        chk("rst_expired", 32'(tif.expired), 32'd0);
        chk("rst_remaining", 32'(tif.remaining), 32'd0);
        chk("rst_tick", 32'(tif.tick_1s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // 1. base run: 6 s = 24 cycles, tick phase-aligned to start
        start_run(2'b00);
        chk("t1_rem_load", 32'(tif.remaining), 32'd6);
        chk("t1_busy", 32'(tif.busy), 32'd1);
        chk("t1_tick_after_start", 32'(tif.tick_1s), 32'd0);
        step(3);
        chk("t1_tick_phase", 32'(tif.tick_1s), 32'd1);
        chk("t1_rem_before_tick", 32'(tif.remaining), 32'd6);
        step(1);
        chk("t1_tick_low", 32'(tif.tick_1s), 32'd0);
        chk("t1_rem_after_tick", 32'(tif.remaining), 32'd5);
        wait_exp("t1", 20);

        // 2. ext reprogrammed to 5 -> 20 cycles; double-base 12 s -> 48 cycles
        reprog(2'b01, 4'd5);
        start_run(2'b01);
        chk("t2_rem_ext", 32'(tif.remaining), 32'd5);
        wait_exp("t2_ext", 20);
        start_run(2'b11);
        chk("t2_rem_dbl", 32'(tif.remaining), 32'd12);
        wait_exp("t2_dbl", 48);

        // 3. zero value and reserved selector writes are ignored
        reprog(2'b10, 4'd0);
        reprog(2'b11, 4'd9);
        start_run(2'b10);
        chk("t3_rem_yel", 32'(tif.remaining), 32'd2);
        wait_exp("t3_yel", 8);

        // 3b. start on the same edge as the final decrement
        start_run(2'b10);
        step(7);
        chk("t3b_rem_last", 32'(tif.remaining), 32'd1);
        tif.start        = 1'b1;
        tif.interval_sel = 2'b01;
        step(1);
        tif.start        = 1'b0;
        chk("t3b_expired", 32'(tif.expired), 32'd1);
        chk("t3b_busy", 32'(tif.busy), 32'd1);
        chk("t3b_rem_reload", 32'(tif.remaining), 32'd5);
        wait_exp("t3b_ext", 20);

        // 4. retrigger base run at E0+10 with yellow -> pulse only at E0+18
        start_run(2'b00);
        count_pulses(9, pulses);
        chk("t4_no_early_pulse", 32'(pulses), 32'd0);
        tif.start        = 1'b1;
        tif.interval_sel = 2'b10;
        step(1);
        tif.start        = 1'b0;
        chk("t4_rem_retrig", 32'(tif.remaining), 32'd2);
        wait_exp("t4_retrig", 8);
        count_pulses(12, pulses);
        chk("t4_no_stale_pulse", 32'(pulses), 32'd0);

        // 5. start and reprogram of base on the same edge: old value used
        tif.start               = 1'b1;
        tif.interval_sel        = 2'b00;
        tif.reprogram           = 1'b1;
        tif.time_param_selector = 2'b00;
        tif.time_value          = 4'd2;
        step(1);
        tif.start     = 1'b0;
        tif.reprogram = 1'b0;
        chk("t5_rem_old", 32'(tif.remaining), 32'd6);
        wait_exp("t5_old", 24);
        start_run(2'b00);
        chk("t5_rem_new", 32'(tif.remaining), 32'd2);
        wait_exp("t5_new", 8);

        // 6. asynchronous reset mid-interval, then defaults restored
        start_run(2'b00);
        step(12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(tif.busy), 32'd0);
        chk("t6_rst_rem", 32'(tif.remaining), 32'd0);
        chk("t6_rst_tick", 32'(tif.tick_1s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(16, pulses);
        chk("t6_no_pulse", 32'(pulses), 32'd0);
        chk("t6_idle", 32'(tif.busy), 32'd0);
        start_run(2'b01);
        chk("t6_rem_def_ext", 32'(tif.remaining), 32'd3);
        wait_exp("t6_ext", 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
